// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared op-class, branch-condition and width definitions for the barrel core
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int NUM_THREADS = 8;
    localparam int THREAD_BITS = $clog2(NUM_THREADS);

    // Control-flow class of the instruction sitting in EX
    typedef enum logic [1:0] {
        OP_NONE   = 2'b00,
        OP_BRANCH = 2'b01,
        OP_JAL    = 2'b10,
        OP_JALR   = 2'b11
    } op_class_e;

    // Per-thread run state
    typedef enum logic {
        TS_RUN    = 1'b0,
        TS_HALTED = 1'b1
    } thread_state_e;

    // Conditional-branch funct3 encodings; 010 and 011 are undefined
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational branch-condition evaluator
module branch_cmp
    import riscv_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    input  logic [2:0]               funct3,
    output logic                     taken
);

    // Evaluate the condition; undefined encodings never branch
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mt_branch_unit.sv
// rtl/mt_branch_unit.sv - execute-stage redirect producer with per-thread halt and taken counters
module mt_branch_unit
    import riscv_pkg::*;
#(
    parameter int NUM_THREADS   = 8,
    parameter int BITS_THREADS  = $clog2(NUM_THREADS),
    parameter int ADDRESS_WIDTH = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_e,
    input  logic [BITS_THREADS-1:0]  tid_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_e,
    input  logic [1:0]               op_e,
    input  logic [2:0]               funct3_e,
    input  logic [ADDRESS_WIDTH-1:0] rs1_e,
    input  logic [ADDRESS_WIDTH-1:0] rs2_e,
    input  logic [ADDRESS_WIDTH-1:0] imm_e,
    input  logic                     halt_e,
    input  logic                     resume_valid,
    input  logic [BITS_THREADS-1:0]  resume_tid,
    input  logic [BITS_THREADS-1:0]  cnt_tid,
    output logic                     pc_src_e,
    output logic [BITS_THREADS-1:0]  branch_tid_e,
    output logic [ADDRESS_WIDTH-1:0] pc_target_e,
    output logic                     misalign_e,
    output logic [NUM_THREADS-1:0]   halted,
    output logic [CNT_WIDTH-1:0]     cnt_value
);

    // JALR clears bit 0 of its sum
    localparam logic [ADDRESS_WIDTH-1:0] JALR_MASK = ~ADDRESS_WIDTH'(1);

    op_class_e                op_cls;
    logic                     cond_taken;
    logic                     taken;
    logic [ADDRESS_WIDTH-1:0] pc_rel_target;
    logic [ADDRESS_WIDTH-1:0] jalr_target;
    logic [ADDRESS_WIDTH-1:0] calc_target;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic                     hold;
    logic                     misaligned;
    logic                     redirect;
    logic [NUM_THREADS-1:0]   halt_req;
    logic [NUM_THREADS-1:0]   resume_req;

    thread_state_e            thread_state [NUM_THREADS];
    logic [CNT_WIDTH-1:0]     taken_cnt    [NUM_THREADS];

    assign op_cls = op_class_e'(op_e);

    branch_cmp #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_branch_cmp (
        .rs1    (rs1_e),
        .rs2    (rs2_e),
        .funct3 (funct3_e),
        .taken  (cond_taken)
    );

    assign pc_rel_target = pc_e + imm_e;
    assign jalr_target   = (rs1_e + imm_e) & JALR_MASK;
    assign pc_plus4      = pc_e + ADDRESS_WIDTH'(4);

    // Resolve the control-flow outcome and the candidate target
    always_comb begin
        taken       = 1'b0;
        calc_target = pc_rel_target;
        case (op_cls)
            OP_BRANCH: taken = cond_taken;
            OP_JAL:    taken = 1'b1;
            OP_JALR: begin
                taken       = 1'b1;
                calc_target = jalr_target;
            end
            default:   taken = 1'b0;
        endcase
    end

    // A held thread (halted, bubble or halting instruction) re-issues its own PC
    assign hold       = halted[tid_e] | ~valid_e | halt_e;
    assign misaligned = ~hold & taken & (calc_target[1:0] != 2'b00);
    assign redirect   = ~hold & taken & ~misaligned;

    // One-hot halt and resume requests for the thread FSMs
    always_comb begin
        halt_req   = '0;
        resume_req = '0;
        if ((valid_e & halt_e) | misaligned) begin
            halt_req[tid_e] = 1'b1;
        end
        if (resume_valid) begin
            resume_req[resume_tid] = 1'b1;
        end
    end

    // Per-thread RUN/HALTED FSM; a halt request beats a resume for the same thread
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                thread_state[i] <= TS_RUN;
            end
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                case (thread_state[i])
                    TS_RUN: begin
                        if (halt_req[i]) begin
                            thread_state[i] <= TS_HALTED;
                        end
                    end
                    TS_HALTED: begin
                        if (resume_req[i] && !halt_req[i]) begin
                            thread_state[i] <= TS_RUN;
                        end
                    end
                    default: thread_state[i] <= TS_RUN;
                endcase
            end
        end
    end

    // Expose the FSM vector as a flat halt mask
    always_comb begin
        halted = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            halted[i] = (thread_state[i] == TS_HALTED);
        end
    end

    // Taken-redirect profiling counters, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                taken_cnt[i] <= '0;
            end
        end else if (redirect && (taken_cnt[tid_e] != '1)) begin
            taken_cnt[tid_e] <= taken_cnt[tid_e] + CNT_WIDTH'(1);
        end
    end

    assign cnt_value = taken_cnt[cnt_tid];

    // Registered PC-file update: exactly one per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_src_e     <= 1'b0;
            branch_tid_e <= '0;
            pc_target_e  <= '0;
            misalign_e   <= 1'b0;
        end else begin
            branch_tid_e <= tid_e;
            misalign_e   <= misaligned;
            if (hold || misaligned) begin
                pc_src_e    <= 1'b1;
                pc_target_e <= pc_e;
            end else if (taken) begin
                pc_src_e    <= 1'b1;
                pc_target_e <= calc_target;
            end else begin
                pc_src_e    <= 1'b0;
                pc_target_e <= pc_plus4;
            end
        end
    end

endmodule

// File: tb/tb_mt_branch_unit.sv
// tb/tb_mt_branch_unit.sv - self-checking bench for mt_branch_unit
module tb_mt_branch_unit;

    localparam int NT      = 8;
    localparam int CNT_MAX = 65535;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_e;
    logic [2:0]  tid_e;
    logic [31:0] pc_e;
    logic [1:0]  op_e;
    logic [2:0]  funct3_e;
    logic [31:0] rs1_e;
    logic [31:0] rs2_e;
    logic [31:0] imm_e;
    logic        halt_e;
    logic        resume_valid;
    logic [2:0]  resume_tid;
    logic [2:0]  cnt_tid;
    logic        pc_src_e;
    logic [2:0]  branch_tid_e;
    logic [31:0] pc_target_e;
    logic        misalign_e;
    logic [7:0]  halted;
    logic [15:0] cnt_value;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  m_halted;
    int unsigned m_cnt [NT];

    always #5 clk = ~clk;

    mt_branch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .valid_e      (valid_e),
        .tid_e        (tid_e),
        .pc_e         (pc_e),
        .op_e         (op_e),
        .funct3_e     (funct3_e),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .imm_e        (imm_e),
        .halt_e       (halt_e),
        .resume_valid (resume_valid),
        .resume_tid   (resume_tid),
        .cnt_tid      (cnt_tid),
        .pc_src_e     (pc_src_e),
        .branch_tid_e (branch_tid_e),
        .pc_target_e  (pc_target_e),
        .misalign_e   (misalign_e),
        .halted       (halted),
        .cnt_value    (cnt_value)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_taken(input logic [1:0] op, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b10 || op == 2'b11) return 1'b1;
        if (op != 2'b01) return 1'b0;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_idle();
        valid_e = 0; tid_e = 0; pc_e = 0; op_e = 0; funct3_e = 0;
        rs1_e = 0; rs2_e = 0; imm_e = 0; halt_e = 0;
        resume_valid = 0; resume_tid = 0;
    endtask

    task automatic instr(input logic [2:0] t, input logic [31:0] pc, input logic [1:0] op,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm);
        valid_e = 1; tid_e = t; pc_e = pc; op_e = op; funct3_e = f3;
        rs1_e = a; rs2_e = b; imm_e = imm; halt_e = 0;
    endtask

    // Predict from the current inputs, clock once, then compare every output
    task automatic cycle();
        logic        e_src;
        logic [2:0]  e_tid;
        logic [31:0] e_tgt;
        logic        e_mis;
        logic        tk;
        logic [31:0] tgt;
        if (rst) begin
            e_src = 0; e_tid = 0; e_tgt = 0; e_mis = 0;
            m_halted = '0;
            for (int i = 0; i < NT; i++) m_cnt[i] = 0;
        end else begin
            tk    = ref_taken(op_e, funct3_e, rs1_e, rs2_e);
            tgt   = (op_e == 2'b11) ? ((rs1_e + imm_e) & 32'hFFFF_FFFE) : (pc_e + imm_e);
            e_tid = tid_e;
            e_mis = 0;
            if (m_halted[tid_e] || !valid_e || halt_e) begin
                e_src = 1; e_tgt = pc_e;
            end else if (tk && tgt[1:0] != 2'b00) begin
                e_src = 1; e_tgt = pc_e; e_mis = 1;
            end else if (tk) begin
                e_src = 1; e_tgt = tgt;
                if (m_cnt[tid_e] < CNT_MAX) m_cnt[tid_e]++;
            end else begin
                e_src = 0; e_tgt = pc_e + 32'd4;
            end
            if (resume_valid) m_halted[resume_tid] = 1'b0;
            if ((valid_e && halt_e) || e_mis) m_halted[tid_e] = 1'b1;
        end
        @(posedge clk);
        #1;
        check("pc_src",    {31'd0, pc_src_e},     {31'd0, e_src});
        check("tid",       {29'd0, branch_tid_e}, {29'd0, e_tid});
        check("target",    pc_target_e,           e_tgt);
        check("misalign",  {31'd0, misalign_e},   {31'd0, e_mis});
        check("halted",    {24'd0, halted},       {24'd0, m_halted});
        check("cnt_value", {16'd0, cnt_value},    m_cnt[cnt_tid]);
    endtask

    initial begin
        set_idle();
        cnt_tid  = 0;
        m_halted = '0;
        for (int i = 0; i < NT; i++) m_cnt[i] = 0;

        rst = 1;
        cycle();
        cycle();
        check("rst_pc_src", {31'd0, pc_src_e}, 32'd0);
        check("rst_target", pc_target_e, 32'd0);
        rst = 0;

        // bubble on tid 3
        tid_e = 3; pc_e = 32'h40; cnt_tid = 3;
        cycle();
        check("bubble_target", pc_target_e, 32'h40);
        check("bubble_src", {31'd0, pc_src_e}, 32'd1);

        // BEQ taken on tid 2
        instr(2, 32'h100, 2'b01, 3'd0, 32'd5, 32'd5, 32'h20); cnt_tid = 2;
        cycle();
        check("beq_target", pc_target_e, 32'h120);
        check("beq_cnt", {16'd0, cnt_value}, 32'd1);

        // signed vs unsigned less-than
        instr(4, 32'h200, 2'b01, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h10);
        cycle();
        check("blt_target", pc_target_e, 32'h210);
        instr(4, 32'h200, 2'b01, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h10);
        cycle();
        check("bltu_src", {31'd0, pc_src_e}, 32'd0);
        check("bltu_target", pc_target_e, 32'h204);

        // misaligned JALR halts thread 6
        instr(6, 32'h300, 2'b11, 3'd0, 32'h203, 32'd0, 32'd0);
        cycle();
        check("jalr_mis", {31'd0, misalign_e}, 32'd1);
        check("jalr_halt6", {31'd0, halted[6]}, 32'd1);
        set_idle(); resume_valid = 1; resume_tid = 6;
        cycle();
        check("mis_pulse_clear", {31'd0, misalign_e}, 32'd0);
        resume_valid = 0;

        // halt request on tid 5, held, resumed, then halt+resume collision
        instr(5, 32'h500, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0); halt_e = 1;
        cycle();
        instr(5, 32'h504, 2'b01, 3'd0, 32'd7, 32'd7, 32'h40);
        cycle();
        check("held_target", pc_target_e, 32'h504);
        set_idle(); resume_valid = 1; resume_tid = 5;
        cycle();
        resume_valid = 0;
        instr(5, 32'h504, 2'b01, 3'd0, 32'd7, 32'd7, 32'h40);
        cycle();
        check("resumed_target", pc_target_e, 32'h544);
        instr(5, 32'h544, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0); halt_e = 1;
        resume_valid = 1; resume_tid = 5;
        cycle();
        check("halt_wins", {31'd0, halted[5]}, 32'd1);
        set_idle();

        // randomized traffic with a mid-run reset
        for (int n = 0; n < 600; n++) begin
            rst          = (n == 300);
            valid_e      = ($urandom_range(0, 7) != 0);
            tid_e        = 3'($urandom);
            pc_e         = $urandom & 32'hFFFF_FFFC;
            op_e         = 2'($urandom);
            funct3_e     = 3'($urandom);
            rs1_e        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            rs2_e        = ($urandom_range(0, 3) == 0) ? rs1_e : $urandom;
            imm_e        = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            halt_e       = ($urandom_range(0, 15) == 0);
            resume_valid = ($urandom_range(0, 2) == 0);
            resume_tid   = 3'($urandom);
            cnt_tid      = 3'($urandom);
            cycle();
        end
        rst = 0;
        set_idle();

        // saturate counter of tid 1 with taken JALs
        set_idle(); resume_valid = 1; resume_tid = 1;
        cycle();
        resume_valid = 0;
        cnt_tid = 1;
        instr(1, 32'h1000, 2'b10, 3'd0, 32'd0, 32'd0, 32'h8);
        for (int n = 0; n < CNT_MAX + 2; n++) begin
            cycle();
        end
        check("cnt_saturated", {16'd0, cnt_value}, 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
